// File: rtl/ssd_scan_controller.sv
// -----------------------------------------------------------------------------
// ssd_scan_controller
//
// Time-multiplexes NUM_DIGITS BCD digits onto one shared 4-bit-to-7-segment
// decoder. Each digit owns a slot of REFRESH_DIV cycles: an ON phase of
// REFRESH_DIV-BLANK_CYCLES cycles with its enable asserted, then a BLANK phase
// of BLANK_CYCLES cycles with every digit off so the shared segment lines can
// settle without ghosting into the next digit.
//
// New display values arrive through a valid/ready handshake into a one-deep
// pending buffer. The buffer is copied to the active (displayed) register only
// at a frame boundary, or at once while scanning is disabled, so one frame never
// shows a mix of old and new digits.
//
// Optional feature (compile-time macro SSD_LEADING_ZERO_BLANK_EN):
//   when defined, digit i>0 shows blank (4'hF) during its ON phase if active
//   digits i..NUM_DIGITS-1 are all zero. Digit enables and timing are unchanged.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   en          in   scan enable; low holds the display dark
//   in_valid    in   new digit set offered on digits_in
//   in_ready    out  pending buffer empty; transfer on in_valid && in_ready
//   digits_in   in   BCD digits, digit i at [4i+3:4i], digit 0 rightmost
//   digit_code  out  decoder data input, 4'hF = blank
//   digit_en    out  one-hot active-high digit enable, all-zero when dark
//   frame_done  out  one-cycle pulse after the last slot of each frame
// -----------------------------------------------------------------------------
module ssd_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    output logic [3:0]              digit_code,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0]      ON_LAST   = CNT_W'(REFRESH_DIV - BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]      SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE_HOT_0 = NUM_DIGITS'(1);

    typedef enum logic {
        S_ON,
        S_BLANK
    } state_t;

    // Scan state
    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // run_q is en delayed by one cycle. The scan only advances once en has
    // been high for a full cycle, so after reset or re-enable the first slot
    // is shown for its complete length.
    logic              run_q;

    // Display data
    logic [4*NUM_DIGITS-1:0] active_q;
    logic [4*NUM_DIGITS-1:0] pending_q;

    // Next output values
    logic [NUM_DIGITS-1:0] en_d;
    logic [3:0]            code_d;

    logic       advance;
    logic       frame_end;
    logic [3:0] cur_code;
    logic [3:0] shown_code;

    assign advance   = en && run_q;
    assign frame_end = advance && (state_q == S_BLANK) && (cnt_q == SLOT_LAST)
                       && (idx_q == IDX_LAST);
    assign cur_code  = active_q[{idx_q, 2'b00} +: 4];

`ifdef SSD_LEADING_ZERO_BLANK_EN
    // upper_zero[i] is set when digits i..NUM_DIGITS-1 are all zero.
    logic [NUM_DIGITS-1:0] digit_zero;
    logic [NUM_DIGITS-1:0] upper_zero;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lz
        assign digit_zero[g] = (active_q[4*g +: 4] == 4'h0);
        assign upper_zero[g] = &digit_zero[NUM_DIGITS-1:g];
    end

    // Digit 0 is never suppressed so a zero value still reads "0".
    assign shown_code = ((idx_q != '0) && upper_zero[idx_q]) ? 4'hF : cur_code;
`else
    assign shown_code = cur_code;
`endif

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its inputs regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_ON;
            idx_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            run_q   <= en;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and next outputs
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        en_d    = '0;
        code_d  = 4'hF;

        if (!en) begin
            // Disabled: park at the start of digit 0 so re-enable begins a
            // fresh frame.
            state_d = S_ON;
            idx_d   = '0;
            cnt_d   = '0;
        end else if (run_q) begin
            unique case (state_q)
                S_ON: begin
                    en_d   = ONE_HOT_0 << idx_q;
                    code_d = shown_code;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == ON_LAST) begin
                        state_d = S_BLANK;
                    end
                end
                S_BLANK: begin
                    if (cnt_q == SLOT_LAST) begin
                        state_d = S_ON;
                        cnt_d   = '0;
                        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_ON;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_en   <= '0;
            digit_code <= 4'hF;
            frame_done <= 1'b0;
        end else begin
            digit_en   <= en_d;
            digit_code <= code_d;
            frame_done <= frame_end;
        end
    end

    // -------------------------------------------------------------------------
    // Handshake and display data
    // -------------------------------------------------------------------------
    // in_ready doubles as the "pending empty" flag. Capture needs it high and
    // transfer to active needs it low, so the two can never happen together;
    // a capture on the boundary cycle therefore waits for the next boundary.
    // NOTE: the data registers are reset as well, because reset must discard
    // pending data and return the visible digits to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q  <= '0;
            pending_q <= '0;
            in_ready  <= 1'b1;
        end else if (in_valid && in_ready) begin
            pending_q <= digits_in;
            in_ready  <= 1'b0;
        end else if (!in_ready && (frame_end || !en)) begin
            active_q <= pending_q;
            in_ready <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ssd_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_ssd_scan_controller
//
// Directed bench for ssd_scan_controller with NUM_DIGITS=4, REFRESH_DIV=8,
// BLANK_CYCLES=2. A slot is 6 ON cycles plus 2 BLANK cycles and a frame is
// 32 cycles. Outputs are sampled 1 time unit after each rising edge.
//
// The variable c is the index, within the current frame sequence, of the scan
// position the outputs are showing: c%8 is the position in the slot, (c/8)%4
// the digit, and c%32==31 is the last BLANK cycle, where frame_done is high.
// -----------------------------------------------------------------------------
module tb_ssd_scan_controller;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;

    // Expected digit codes shown for a given active value (digit 3 .. digit 0).
`ifdef SSD_LEADING_ZERO_BLANK_EN
    localparam logic [15:0] DISP_0000 = 16'hFFF0;
    localparam logic [15:0] DISP_0040 = 16'hFF40;
`else
    localparam logic [15:0] DISP_0000 = 16'h0000;
    localparam logic [15:0] DISP_0040 = 16'h0040;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   digits_in;
    logic [3:0]    digit_code;
    logic [ND-1:0] digit_en;
    logic          frame_done;

    int errors = 0;
    int checks = 0;
    int c;

    ssd_scan_controller #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .digits_in (digits_in),
        .digit_code(digit_code),
        .digit_en  (digit_en),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_en(input int cc);
        int pos;
        int slot;
        pos  = cc % 8;
        slot = (cc / 8) % 4;
        return (pos < 6) ? (4'b0001 << slot) : 4'b0000;
    endfunction

    function automatic logic [3:0] exp_code(input int cc, input logic [15:0] disp);
        int pos;
        int slot;
        pos  = cc % 8;
        slot = (cc / 8) % 4;
        return (pos < 6) ? disp[slot*4 +: 4] : 4'hF;
    endfunction

    function automatic logic exp_done(input int cc);
        return (cc % 32) == 31;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
        c++;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset;
        rst_n     = 1'b0;
        en        = 1'b1;
        in_valid  = 1'b0;
        digits_in = 16'h0000;
        #23;
        checks++; if (digit_en !== 4'b0000) begin errors++; $display("FAIL reset digit_en got %b exp 0000", digit_en); end
        checks++; if (digit_code !== 4'hF) begin errors++; $display("FAIL reset digit_code got %h exp f", digit_code); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset frame_done got %b exp 0", frame_done); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b exp 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        c = -1;
        tick();
        c = -1;
        // First edge after release: scan not yet running, still dark.
        checks++; if (digit_en !== 4'b0000) begin errors++; $display("FAIL first_edge digit_en got %b exp 0000", digit_en); end
        checks++; if (digit_code !== 4'hF) begin errors++; $display("FAIL first_edge digit_code got %h exp f", digit_code); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_scan;
        // Two full frames with active = 0.
        for (int k = 0; k < 64; k++) begin
            tick();
            checks++; if (digit_en !== exp_en(c)) begin errors++; $display("FAIL scan digit_en c=%0d got %b exp %b", c, digit_en, exp_en(c)); end
            checks++; if (digit_code !== exp_code(c, DISP_0000)) begin errors++; $display("FAIL scan digit_code c=%0d got %h exp %h", c, digit_code, exp_code(c, DISP_0000)); end
            checks++; if (frame_done !== exp_done(c)) begin errors++; $display("FAIL scan frame_done c=%0d got %b exp %b", c, frame_done, exp_done(c)); end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_load;
        logic [15:0] disp;
        logic        rdy;
        // Offer 1234 mid-frame, hold in_valid with different data while not
        // ready, and expect 1234 from the frame after the boundary at c=95.
        while (c < 127) begin
            if (c == 70) begin in_valid = 1'b1; digits_in = 16'h1234; end
            if (c == 71) digits_in = 16'hAAAA;
            if (c == 74) in_valid = 1'b0;
            tick();
            disp = (c >= 96) ? 16'h1234 : DISP_0000;
            rdy  = (c >= 71 && c < 95) ? 1'b0 : 1'b1;
            checks++; if (digit_en !== exp_en(c)) begin errors++; $display("FAIL load digit_en c=%0d got %b exp %b", c, digit_en, exp_en(c)); end
            checks++; if (digit_code !== exp_code(c, disp)) begin errors++; $display("FAIL load digit_code c=%0d got %h exp %h", c, digit_code, exp_code(c, disp)); end
            checks++; if (frame_done !== exp_done(c)) begin errors++; $display("FAIL load frame_done c=%0d got %b exp %b", c, frame_done, exp_done(c)); end
            checks++; if (in_ready !== rdy) begin errors++; $display("FAIL load in_ready c=%0d got %b exp %b", c, in_ready, rdy); end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_boundary_capture;
        logic [15:0] disp;
        logic        rdy;
        // in_valid is sampled on the boundary edge of c=159: 5678 must wait
        // until the boundary at c=191 and show from c=192.
        while (c < 223) begin
            if (c == 158) begin in_valid = 1'b1; digits_in = 16'h5678; end
            if (c == 159) in_valid = 1'b0;
            tick();
            disp = (c >= 192) ? 16'h5678 : 16'h1234;
            rdy  = (c >= 159 && c < 191) ? 1'b0 : 1'b1;
            checks++; if (digit_en !== exp_en(c)) begin errors++; $display("FAIL bnd digit_en c=%0d got %b exp %b", c, digit_en, exp_en(c)); end
            checks++; if (digit_code !== exp_code(c, disp)) begin errors++; $display("FAIL bnd digit_code c=%0d got %h exp %h", c, digit_code, exp_code(c, disp)); end
            checks++; if (frame_done !== exp_done(c)) begin errors++; $display("FAIL bnd frame_done c=%0d got %b exp %b", c, frame_done, exp_done(c)); end
            checks++; if (in_ready !== rdy) begin errors++; $display("FAIL bnd in_ready c=%0d got %b exp %b", c, in_ready, rdy); end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_en_drop;
        logic rdy;
        // Run to digit 2 ON (c=242), then drop en for 5 cycles. While dark,
        // load 9ABC (above-9 codes pass through) which is copied to active
        // immediately and shown after re-enable.
        while (c < 242) begin
            tick();
            checks++; if (digit_en !== exp_en(c)) begin errors++; $display("FAIL pre_drop digit_en c=%0d got %b exp %b", c, digit_en, exp_en(c)); end
            checks++; if (digit_code !== exp_code(c, 16'h5678)) begin errors++; $display("FAIL pre_drop digit_code c=%0d got %h exp %h", c, digit_code, exp_code(c, 16'h5678)); end
        end
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 0) begin in_valid = 1'b1; digits_in = 16'h9ABC; end
            if (k == 1) in_valid = 1'b0;
            rdy = (k == 1) ? 1'b0 : 1'b1;
            checks++; if (digit_en !== 4'b0000) begin errors++; $display("FAIL dark digit_en k=%0d got %b exp 0000", k, digit_en); end
            checks++; if (digit_code !== 4'hF) begin errors++; $display("FAIL dark digit_code k=%0d got %h exp f", k, digit_code); end
            checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL dark frame_done k=%0d got %b exp 0", k, frame_done); end
            checks++; if (in_ready !== rdy) begin errors++; $display("FAIL dark in_ready k=%0d got %b exp %b", k, in_ready, rdy); end
        end
        en = 1'b1;
        tick();
        checks++; if (digit_en !== 4'b0000) begin errors++; $display("FAIL reen_edge digit_en got %b exp 0000", digit_en); end
        c = -1;
        // One full frame restarting at digit 0 with a full 6-cycle ON.
        for (int k = 0; k < 32; k++) begin
            tick();
            checks++; if (digit_en !== exp_en(c)) begin errors++; $display("FAIL reen digit_en c=%0d got %b exp %b", c, digit_en, exp_en(c)); end
            checks++; if (digit_code !== exp_code(c, 16'h9ABC)) begin errors++; $display("FAIL reen digit_code c=%0d got %h exp %h", c, digit_code, exp_code(c, 16'h9ABC)); end
            checks++; if (frame_done !== exp_done(c)) begin errors++; $display("FAIL reen frame_done c=%0d got %b exp %b", c, frame_done, exp_done(c)); end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_mid_blank;
        // Capture 4321 (pending full), then reset during digit 0 BLANK (c=38).
        while (c < 38) begin
            if (c == 34) begin in_valid = 1'b1; digits_in = 16'h4321; end
            if (c == 35) in_valid = 1'b0;
            tick();
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pre_rst in_ready got %b exp 0", in_ready); end
        checks++; if (digit_code !== 4'hF) begin errors++; $display("FAIL pre_rst digit_code got %h exp f", digit_code); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (digit_en !== 4'b0000) begin errors++; $display("FAIL mid_rst digit_en got %b exp 0000", digit_en); end
        checks++; if (digit_code !== 4'hF) begin errors++; $display("FAIL mid_rst digit_code got %h exp f", digit_code); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL mid_rst frame_done got %b exp 0", frame_done); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst in_ready got %b exp 1", in_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        c = -1;
        // 40 cycles: pending was discarded, so nothing changes at c=31.
        for (int k = 0; k < 40; k++) begin
            tick();
            checks++; if (digit_en !== exp_en(c)) begin errors++; $display("FAIL post_rst digit_en c=%0d got %b exp %b", c, digit_en, exp_en(c)); end
            checks++; if (digit_code !== exp_code(c, DISP_0000)) begin errors++; $display("FAIL post_rst digit_code c=%0d got %h exp %h", c, digit_code, exp_code(c, DISP_0000)); end
            checks++; if (frame_done !== exp_done(c)) begin errors++; $display("FAIL post_rst frame_done c=%0d got %b exp %b", c, frame_done, exp_done(c)); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst in_ready c=%0d got %b exp 1", c, in_ready); end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_zero_digits;
        logic [15:0] disp;
        // Load 0040 (shown c=64..127), then 0000 (shown from c=128).
        while (c < 159) begin
            if (c == 40) begin in_valid = 1'b1; digits_in = 16'h0040; end
            if (c == 96) begin in_valid = 1'b1; digits_in = 16'h0000; end
            if (c == 41 || c == 97) in_valid = 1'b0;
            tick();
            disp = (c >= 128) ? DISP_0000 : (c >= 64) ? DISP_0040 : DISP_0000;
            checks++; if (digit_en !== exp_en(c)) begin errors++; $display("FAIL zero digit_en c=%0d got %b exp %b", c, digit_en, exp_en(c)); end
            checks++; if (digit_code !== exp_code(c, disp)) begin errors++; $display("FAIL zero digit_code c=%0d got %h exp %h", c, digit_code, exp_code(c, disp)); end
        end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        test_reset();
        test_scan();
        test_load();
        test_boundary_capture();
        test_en_drop();
        test_reset_mid_blank();
        test_zero_digits();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
